// File: rtl/ascon_serial_io.sv
// Serial load/unload port for masked Ascon cores: W-bit-per-share lanes in,
// share-split parallel fields out, and MSB-first serialised text/tag back out.

// One share of one field: shifts lanes in MSB-first and keeps only the top R
// lane bits on a short final beat.
module ascon_field_sr #(
  parameter int N  = 128,
  parameter int W  = 1,
  parameter int BW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          capture,
  input  logic [BW-1:0] beat,
  input  logic [W-1:0]  lane,
  output logic [N-1:0]  fieldReg
);
  localparam int NFULL = N / W;
  localparam int REM   = N % W;
  localparam logic [BW-1:0] FULL_BEATS = BW'(NFULL);

  logic [N+W-1:0] ext;
  assign ext = {fieldReg, lane};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      fieldReg <= '0;
    end else if (capture) begin
      if (beat < FULL_BEATS) begin
        fieldReg <= ext[N-1:0];
      end else if (REM != 0 && beat == FULL_BEATS) begin
        fieldReg <= ext[N+W-REM-1 -: N];
      end
    end
  end
endmodule

module ascon_serial_io #(
  parameter int K      = 128,
  parameter int L      = 40,
  parameter int Y      = 80,
  parameter int W      = 1,
  parameter int SHARES = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid_i,
  output logic                  load_ready_o,
  input  logic [SHARES*W-1:0]   key_i,
  input  logic [SHARES*W-1:0]   nonce_i,
  input  logic [SHARES*W-1:0]   ad_i,
  input  logic [SHARES*W-1:0]   text_i,
  output logic [SHARES*K-1:0]   key_o,
  output logic [SHARES*128-1:0] nonce_o,
  output logic [SHARES*L-1:0]   ad_o,
  output logic [SHARES*Y-1:0]   text_o,
  output logic                  start_o,
  input  logic                  core_done_i,
  input  logic [Y-1:0]          core_text_i,
  input  logic [127:0]          core_tag_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [W-1:0]          text_so,
  output logic [W-1:0]          tag_so,
  output logic                  out_last_o,
  output logic                  busy_o
);
  localparam int MAXKN  = (K > 128) ? K : 128;
  localparam int MAXLY  = (L > Y) ? L : Y;
  localparam int MAXIN  = (MAXKN > MAXLY) ? MAXKN : MAXLY;
  localparam int NIN    = (MAXIN + W - 1) / W;
  localparam int MAXOUT = (Y > 128) ? Y : 128;
  localparam int NOUT   = (MAXOUT + W - 1) / W;
  localparam int BW     = $clog2(NIN + 1);
  localparam int JW     = $clog2(NOUT + 1);
  localparam logic [BW-1:0] LAST_IN  = BW'(NIN - 1);
  localparam logic [JW-1:0] LAST_OUT = JW'(NOUT - 1);

  typedef enum logic [1:0] {LOAD, START, WAIT, UNLOAD} stateT;

  stateT         state, nextState;
  logic [BW-1:0] beat;
  logic [JW-1:0] outBeat;
  logic [Y-1:0]  textSr;
  logic [127:0]  tagSr;
  logic          loadFire, outFire;

  assign loadFire = (state == LOAD) && load_valid_i;
  assign outFire  = (state == UNLOAD) && out_ready_i;

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= nextState;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    nextState    = state;
    load_ready_o = 1'b0;
    start_o      = 1'b0;
    out_valid_o  = 1'b0;
    out_last_o   = 1'b0;
    busy_o       = 1'b1;
    case (state)
      LOAD: begin
        load_ready_o = 1'b1;
        busy_o       = 1'b0;
        if (load_valid_i && beat == LAST_IN) nextState = START;
      end
      START: begin
        start_o   = 1'b1;
        nextState = WAIT;
      end
      WAIT: begin
        if (core_done_i) nextState = UNLOAD;
      end
      UNLOAD: begin
        out_valid_o = 1'b1;
        out_last_o  = (outBeat == LAST_OUT);
        if (out_ready_i && outBeat == LAST_OUT) nextState = LOAD;
      end
      default: nextState = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat <= '0;
    end else if (loadFire) begin
      beat <= (beat == LAST_IN) ? '0 : beat + 1'b1;
    end
  end

  // Left shift drains the registers MSB-first and backfills zeros past bit 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      textSr  <= '0;
      tagSr   <= '0;
      outBeat <= '0;
    end else if (state == WAIT && core_done_i) begin
      textSr  <= core_text_i;
      tagSr   <= core_tag_i;
      outBeat <= '0;
    end else if (outFire) begin
      textSr  <= textSr << W;
      tagSr   <= tagSr << W;
      outBeat <= outBeat + 1'b1;
    end
  end

  assign text_so = textSr[Y-1 -: W];
  assign tag_so  = tagSr[127 -: W];

  for (genvar s = 0; s < SHARES; s++) begin : gShare
    ascon_field_sr #(.N(K), .W(W), .BW(BW)) uKey (
      .clk(clk), .rst(rst), .capture(loadFire), .beat(beat),
      .lane(key_i[s*W +: W]), .fieldReg(key_o[s*K +: K]));
    ascon_field_sr #(.N(128), .W(W), .BW(BW)) uNonce (
      .clk(clk), .rst(rst), .capture(loadFire), .beat(beat),
      .lane(nonce_i[s*W +: W]), .fieldReg(nonce_o[s*128 +: 128]));
    ascon_field_sr #(.N(L), .W(W), .BW(BW)) uAd (
      .clk(clk), .rst(rst), .capture(loadFire), .beat(beat),
      .lane(ad_i[s*W +: W]), .fieldReg(ad_o[s*L +: L]));
    ascon_field_sr #(.N(Y), .W(W), .BW(BW)) uText (
      .clk(clk), .rst(rst), .capture(loadFire), .beat(beat),
      .lane(text_i[s*W +: W]), .fieldReg(text_o[s*Y +: Y]));
  end
endmodule

// File: tb/tb_ascon_serial_io.sv
// Bench for ascon_serial_io at lane widths 1, 8 and 3: random stalls, a bit-stream
// reference model for field capture and serialised unload.
module tb_ascon_serial_io;
  localparam int SH = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int nTests = 0;
  int nFail  = 0;
  int doneCnt = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int fieldLen(input int f);
    case (f)
      0, 1:    return 128;
      2:       return 40;
      default: return 80;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int LW   = (g == 0) ? 1 : ((g == 1) ? 8 : 3);
    localparam int NIN  = (128 + LW - 1) / LW;
    localparam int NOUT = (128 + LW - 1) / LW;

    logic              rst, loadValid, loadReady, start, coreDone;
    logic              outValid, outReady, outLast, busy;
    logic [SH*LW-1:0]  keyIn, nonceIn, adIn, textIn;
    logic [SH*128-1:0] keyOut, nonceOut;
    logic [SH*40-1:0]  adOut;
    logic [SH*80-1:0]  textOut;
    logic [79:0]       coreText;
    logic [127:0]      coreTag;
    logic [LW-1:0]     textSo, tagSo;
    logic [127:0]      fv [4][SH];

    ascon_serial_io #(.K(128), .L(40), .Y(80), .W(LW), .SHARES(SH)) dut (
      .clk(clk), .rst(rst),
      .load_valid_i(loadValid), .load_ready_o(loadReady),
      .key_i(keyIn), .nonce_i(nonceIn), .ad_i(adIn), .text_i(textIn),
      .key_o(keyOut), .nonce_o(nonceOut), .ad_o(adOut), .text_o(textOut),
      .start_o(start), .core_done_i(coreDone),
      .core_text_i(coreText), .core_tag_i(coreTag),
      .out_valid_o(outValid), .out_ready_i(outReady),
      .text_so(textSo), .tag_so(tagSo), .out_last_o(outLast), .busy_o(busy));

    // Each share sees a bit stream, lane bit LW-1 first; a field is the first N bits.
    function automatic logic [SH*LW-1:0] laneFor(input int f, input int b);
      logic [SH*LW-1:0] v;
      int pos;
      v = '0;
      for (int s = 0; s < SH; s++)
        for (int k = 0; k < LW; k++) begin
          pos = b * LW + (LW - 1 - k);
          if (pos < fieldLen(f)) v[s*LW+k] = fv[f][s][fieldLen(f)-1-pos];
          else                   v[s*LW+k] = 1'($urandom);
        end
      return v;
    endfunction

    task automatic setVectors(input bit useKat);
      for (int f = 0; f < 4; f++)
        for (int s = 0; s < SH; s++)
          fv[f][s] = rnd128() >> (128 - fieldLen(f));
      if (useKat) begin
        fv[0][0] = 128'h2db083053e848cefa30007336c47a5a1;
        fv[1][0] = 128'h3f3607dbce3503ba84f5843d623de056;
        fv[2][0] = 128'h4153434f4e;
        fv[3][0] = 128'h87a59a2ea49b233259e3;
      end
    endtask

    task automatic doLoad(input int abortAt, input int strayAt);
      int b = 0;
      int cyc = 0;
      bit early = 0;
      bit strayPending = 0;
      bit strayDone = 0;
      while (b < NIN && cyc < 20 * NIN) begin
        @(negedge clk);
        cyc++;
        if (start) early = 1;
        if (strayPending) begin
          check($sformatf("W%0d stray done valid", LW), outValid, 0);
          check($sformatf("W%0d stray done busy", LW), busy, 0);
          coreDone = 1'b0;
          strayPending = 0;
        end
        if (b == abortAt) begin
          loadValid = 1'b0;
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          return;
        end
        if (b == strayAt && !strayDone) begin
          loadValid = 1'b0;
          coreDone = 1'b1;
          strayDone = 1;
          strayPending = 1;
        end else begin
          loadValid = ($urandom % 4) != 0;
        end
        keyIn   = loadValid ? laneFor(0, b) : SH*LW'($urandom);
        nonceIn = loadValid ? laneFor(1, b) : SH*LW'($urandom);
        adIn    = loadValid ? laneFor(2, b) : SH*LW'($urandom);
        textIn  = loadValid ? laneFor(3, b) : SH*LW'($urandom);
        if (loadValid && loadReady) b++;
      end
      check($sformatf("W%0d load beats", LW), b, NIN);
      check($sformatf("W%0d start early", LW), early, 0);
      @(negedge clk);
      loadValid = 1'b0;
      check($sformatf("W%0d start pulse", LW), start, 1);
      @(negedge clk);
      check($sformatf("W%0d start one cycle", LW), start, 0);
      check($sformatf("W%0d busy in wait", LW), busy, 1);
    endtask

    task automatic checkFields();
      for (int s = 0; s < SH; s++) begin
        check($sformatf("W%0d key s%0d", LW, s), keyOut[s*128 +: 128], fv[0][s]);
        check($sformatf("W%0d nonce s%0d", LW, s), nonceOut[s*128 +: 128], fv[1][s]);
        check($sformatf("W%0d ad s%0d", LW, s), adOut[s*40 +: 40], fv[2][s]);
        check($sformatf("W%0d text s%0d", LW, s), textOut[s*80 +: 80], fv[3][s]);
      end
    endtask

    task automatic doUnload(input logic [79:0] t, input logic [127:0] tg);
      logic [159:0] accT, accG, expT, expG;
      logic [127:0] r;
      logic [LW-1:0] prevT, prevG;
      int j = 0;
      int cyc = 0;
      bit stalled = 0;
      accT = '0;
      accG = '0;
      @(negedge clk);
      check($sformatf("W%0d valid in wait", LW), outValid, 0);
      coreText = t;
      coreTag  = tg;
      coreDone = 1'b1;
      @(negedge clk);
      coreDone = 1'b0;
      r = rnd128();
      coreText = r[79:0];
      coreTag  = rnd128();
      check($sformatf("W%0d valid after done", LW), outValid, 1);
      while (j < NOUT && cyc < 20 * NOUT) begin
        if (stalled) begin
          check($sformatf("W%0d text hold", LW), textSo, prevT);
          check($sformatf("W%0d tag hold", LW), tagSo, prevG);
        end
        prevT = textSo;
        prevG = tagSo;
        outReady = ($urandom % 3) != 0;
        if (outValid && outReady) begin
          accT = (accT << LW) | 160'(textSo);
          accG = (accG << LW) | 160'(tagSo);
          check($sformatf("W%0d last beat %0d", LW, j), outLast, (j == NOUT - 1));
          j++;
          stalled = 0;
        end else begin
          stalled = 1;
        end
        @(negedge clk);
        cyc++;
      end
      outReady = 1'b0;
      check($sformatf("W%0d unload beats", LW), j, NOUT);
      expT = 160'(t) << (NOUT * LW - 80);
      expG = 160'(tg) << (NOUT * LW - 128);
      check($sformatf("W%0d unload text", LW), accT, expT);
      check($sformatf("W%0d unload tag", LW), accG, expG);
      check($sformatf("W%0d valid after last", LW), outValid, 0);
      check($sformatf("W%0d ready after last", LW), loadReady, 1);
    endtask

    initial begin
      logic [127:0] r;
      rst = 1'b1;
      loadValid = 1'b0;
      outReady = 1'b0;
      coreDone = 1'b0;
      coreText = '0;
      coreTag = '0;
      keyIn = '0;
      nonceIn = '0;
      adIn = '0;
      textIn = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check($sformatf("W%0d reset ready", LW), loadReady, 1);
      check($sformatf("W%0d reset busy", LW), busy, 0);
      check($sformatf("W%0d reset start", LW), start, 0);
      check($sformatf("W%0d reset valid", LW), outValid, 0);
      check($sformatf("W%0d reset last", LW), outLast, 0);
      check($sformatf("W%0d reset key", LW), keyOut, 0);
      check($sformatf("W%0d reset text lane", LW), textSo, 0);

      setVectors(1'b1);
      doLoad(-1, -1);
      checkFields();
      doUnload(80'h0123456789abcdef0123, rnd128());

      setVectors(1'b0);
      doLoad((NIN / 2 < 50) ? NIN / 2 : 50, -1);
      check($sformatf("W%0d abort key cleared", LW), keyOut, 0);
      check($sformatf("W%0d abort ad cleared", LW), adOut, 0);
      check($sformatf("W%0d abort ready", LW), loadReady, 1);
      setVectors(1'b0);
      doLoad(-1, NIN / 3);
      checkFields();
      r = rnd128();
      doUnload(r[79:0], rnd128());
      doneCnt++;
    end
  end

  initial begin
    for (int i = 0; i < 50000 && doneCnt < 3; i++) @(posedge clk);
    check("all configs finished", doneCnt, 3);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule

// File: doc/ascon_serial_io.md
# ascon_serial_io

Parametrised serial load/unload port for the masked Ascon cores. It deserialises key, nonce, associated data and text from W-bit-per-share lanes into share-split parallel registers, and issues a one-cycle start pulse to the core. When the core reports done, it captures the result text and tag and serialises them out MSB-first under a valid/ready handshake. It generalises the fixed 1-bit-per-cycle serial interface to any lane width, any share count and back-pressured output.

## Interface
- K, 128, key length in bits
- L, 40, associated-data length in bits
- Y, 80, text length in bits (plain or cipher)
- W, 1, lane width: bits per share per beat (1..32)
- SHARES, 3, number of masking shares; share s occupies lane bits [s*W +: W]
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- load_valid_i  in  1  input beat valid
- load_ready_o  out  1  input beat accepted when valid&ready
- key_i, nonce_i, ad_i, text_i  in  SHARES*W  input lanes
- key_o  out  SHARES*K  share-split key, share s at [s*K +: K]
- nonce_o  out  SHARES*128  share-split nonce
- ad_o  out  SHARES*L  share-split associated data
- text_o  out  SHARES*Y  share-split text
- start_o  out  1  one-cycle core start pulse
- core_done_i  in  1  core result valid (level or pulse)
- core_text_i  in  Y  core result text
- core_tag_i  in  128  core result tag
- out_valid_o  out  1  output beat valid
- out_ready_i  in  1  output beat consumed when valid&ready
- text_so, tag_so  out  W  output lanes; lane bit W-1 is earliest in time
- out_last_o  out  1  final output beat
- busy_o  out  1  high in every state except LOAD

## Operation
- MAXIN = max(K,128,L,Y); NIN = ceil(MAXIN/W); MAXOUT = max(Y,128); NOUT = ceil(MAXOUT/W).
- FSM: LOAD -> START -> WAIT -> UNLOAD -> LOAD.
- LOAD: load_ready_o=1. Each handshake is beat b (0..NIN-1), and beat counter b increments.
  - A field of length N captures on beats b < ceil(N/W), MSB-first, into each share independently: reg = {reg, lane}.
  - If N mod W = R ≠ 0, its final beat appends only lane bits [W-1:W-R].
  - Lanes on beats past a field's length are ignored.
  - The beat b = NIN-1 handshake moves the FSM to START.
- START: start_o=1 for exactly one cycle, then WAIT. Field outputs are stable from START until the next LOAD handshake.
- WAIT: on core_done_i, capture core_text_i and core_tag_i into output shift registers, clear the output beat counter, and go to UNLOAD. core_done_i is ignored in every other state.
- UNLOAD: out_valid_o=1.
  - Beat j presents text bits [Y-1-jW -: W] on text_so; positions below bit 0 read as 0. tag_so follows the same rule on 128 bits.
  - On a handshake, both registers shift left by W and j increments.
  - out_last_o=1 while j = NOUT-1. The handshake on that beat returns the FSM to LOAD and clears b.
- Field registers are not cleared on return to LOAD; new beats overwrite them.
- In LOAD, load_valid_i=0 stalls; in UNLOAD, out_ready_i=0 stalls. Lanes and outputs hold during stalls.

## Timing
- Reset (rst high at a clock edge):
  - State LOAD; all counters and registers zero.
  - start_o=0, out_valid_o=0, out_last_o=0, busy_o=0, text_so=tag_so=0, all field outputs 0.
  - load_ready_o=1 in the first cycle after reset.
- rst overrides every state, including mid-load and mid-unload. Partial data is discarded.
- load_ready_o, out_valid_o and out_last_o are decoded from state and counters. text_so and tag_so are registered.
- start_o is high in the cycle after the final load handshake.
- out_valid_o is high in the cycle after core_done_i is sampled in WAIT.
- Minimum transaction length: NIN + 1 + 1 + NOUT cycles, plus core latency.

## Test plan
- Reset: hold rst 2 cycles, release -> load_ready_o=1, busy_o=0, start_o=0, out_valid_o=0, key_o=0.
- W=1, SHARES=3, 128 beats:
  - Stimulus: key 2db083053e848cefa30007336c47a5a1, nonce 3f3607dbce3503ba84f5843d623de056, ad 4153434f4e, text 87a59a2ea49b233259e3 on share 0; random shares 1–2.
  - Required: share-0 slices equal those values, and start_o pulses exactly one cycle after beat 127.
- W=8 (16 beats) and W=3 (43 beats):
  - Same vectors.
  - W=3: ad captures on beats 0..13, with beat 13 using lane bit [2] only.
  - Required: share-0 fields match bit-exactly.
- Unload, W=1:
  - core_done_i with core_text_i=0123456789abcdef0123 and tag 0x1f…e0 (any).
  - Toggle out_ready_i randomly.
  - Required: collected 128 beats give the text in the top 80 bits followed by 48 zero bits, and the exact tag; out_last_o only on beat 127; lanes hold while stalled.
- Reset mid-load at beat 50, then a full reload -> fields reflect only the new load, and start_o fires after beat NIN-1 of the new load.
- Stray core_done_i pulse in LOAD -> ignored: out_valid_o stays 0 and b is unchanged.
